// File: rtl/serial_adder_if.sv
// Handshake and result bundle for the bit-serial adder.
// The master drives the operands; the slave returns the status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] Xin;
  logic [WIDTH-1:0] Yin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             CarryOut;

  modport master (
    output Start, Xin, Yin,
    input  Busy, Done, Sum, CarryOut
  );

  modport slave (
    input  Start, Xin, Yin,
    output Busy, Done, Sum, CarryOut
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per cycle, LSB first.
// Result and carry are registered on entry to DONE and held until the next result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           Clk,
  input logic           Reset,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-2:0] psum;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;

  logic             s1;
  logic             c1;
  logic             sbit;
  logic             c2;
  logic             carry_next;
  logic             last;
  logic [WIDTH-1:0] psum_next;

  // Two cascaded half adders on the operand LSBs and the carry flop.
  always_comb begin
    s1         = x_sr[0] ^ y_sr[0];
    c1         = x_sr[0] & y_sr[0];
    sbit       = s1 ^ carry;
    c2         = s1 & carry;
    carry_next = c1 | c2;
    last       = (cnt == LAST);
    psum_next  = {sbit, psum};
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status decode from the registered state.
  always_comb begin
    state_next = state;
    bus.Busy   = 1'b0;
    bus.Done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) state_next = ADD;
      end
      ADD: begin
        bus.Busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.Done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, carry, counter and result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_sr   <= '0;
      y_sr   <= '0;
      psum   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            x_sr  <= bus.Xin;
            y_sr  <= bus.Yin;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        ADD: begin
          x_sr  <= x_sr >> 1;
          y_sr  <= y_sr >> 1;
          psum  <= psum_next[WIDTH-1:1];
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= psum_next;
            cout_q <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Sum      = sum_q;
  assign bus.CarryOut = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: request to add Xin and Yin.
REQ-005 The block SHALL have port Xin, input, WIDTH bits: operand X, sampled only when Start is accepted.
REQ-006 The block SHALL have port Yin, input, WIDTH bits: operand Y, sampled only when Start is accepted.
REQ-007 The block SHALL have port Busy, output, 1 bit: high while bit-serial addition is in progress.
REQ-008 The block SHALL have port Done, output, 1 bit: single-cycle pulse marking a completed result.
REQ-009 The block SHALL have port Sum, output, WIDTH bits: registered result of X+Y modulo 2^WIDTH.
REQ-010 The block SHALL have port CarryOut, output, 1 bit: registered carry out of bit WIDTH-1.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, ADD and DONE, and IDLE SHALL be the reset state.
REQ-012 In IDLE with Start=1 at a rising edge, the block SHALL load Xin/Yin into internal right-shift registers, clear the carry flop, clear the bit counter and enter ADD.
REQ-013 In IDLE with Start=0, the block SHALL remain in IDLE with all registers held.
REQ-014 Each ADD cycle SHALL process the operand LSBs x, y and carry c as two cascaded half-adder stages: s1=x^y, c1=x&y, bit=s1^c, c2=s1&c, carry_next=c1|c2.
REQ-015 Each ADD cycle SHALL shift bit into the MSB of an internal partial-sum shift register, shift both operand registers right by one, update the carry flop and increment the counter.
REQ-016 On the edge processing bit WIDTH-1, the block SHALL load the Sum register with the complete partial sum including that bit, load CarryOut with carry_next and enter DONE.
REQ-017 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-018 Busy SHALL be 1 in ADD only, and Done SHALL be 1 in DONE only; both outputs SHALL be decoded from registered state.
REQ-019 Latency: with Start sampled at edge k, Done SHALL be high in the cycle after edge k+WIDTH.
REQ-020 Throughput: with Start held high continuously, one addition SHALL complete every WIDTH+2 cycles.
REQ-021 Start SHALL be ignored in ADD and DONE, with no effect on the operand registers, carry or counter.
REQ-022 Sum and CarryOut SHALL change only on entry to DONE or on reset, and SHALL hold their values through IDLE and a subsequent ADD until the next result is loaded.
REQ-023 Xin and Yin changing during ADD SHALL have no effect on the result in progress.
REQ-024 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap within one operation.

Reset
REQ-025 With Reset=1 at a rising edge, the block SHALL set the state to IDLE and clear Busy, Done, Sum, CarryOut, the carry flop, the counter and all shift registers to 0.
REQ-026 Reset SHALL take priority over Start and over every state transition.
REQ-027 Reset asserted mid-ADD or in DONE SHALL abort the operation, produce no Done pulse and return to IDLE at the next edge.

Verification
REQ-028 With WIDTH=8, Start pulsed with Xin=0x3C and Yin=0x5A at edge 0, the bench SHALL check Busy is high after edges 1..7, Done=1 after edge 8, Sum=0x96 and CarryOut=0.
REQ-029 With WIDTH=8, 0xFF+0x01 SHALL give Sum=0x00 and CarryOut=1, and 0xFF+0xFF SHALL give Sum=0xFE and CarryOut=1.
REQ-030 With WIDTH=8 and Start held high with constant operands 0x01+0x01, the bench SHALL check that Done pulses every 10 cycles and Sum=0x02 on each pulse.
REQ-031 For Start re-pulsed mid-ADD with Xin=0xAA and Yin=0x55 during an in-progress 0x10+0x20, the bench SHALL check that the result is Sum=0x30 and that no extra Done occurs.
REQ-032 For Reset asserted after edge 4 of an operation, the bench SHALL check that the next cycle is IDLE, Sum=0x00, CarryOut=0, no Done pulse, and that a following Start computes correctly.
REQ-033 With WIDTH=4, 0xF+0xF SHALL give Sum=0xE, CarryOut=1, and Done after edge 4.
